// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word per instruction, holds it for execute,
// then advances the PC sequentially, by branch offset or by jump target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o32,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i32,
  output logic [31:0] instr_o32,
  output logic [5:0]  op_o6,
  output logic [5:0]  funct_o6,
  output logic        instr_valid_o,
  input  logic        exec_done_i,
  input  logic        pc_beq_i,
  input  logic        pc_j_i,
  output logic [31:0] pc_o32,
  output logic [31:0] pc_plus4_o32,
  output logic        err_o
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pc_load;
  logic             w_instr_load;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_off;
  logic [31:0]      w_pc_nxt;

  // Next-PC selection: jump beats branch beats sequential.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_pc_nxt = w_pc_plus4;
    if (pc_j_i) begin
      w_pc_nxt = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (pc_beq_i) begin
      w_pc_nxt = w_pc_plus4 + w_br_off;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter is zero outside REQ, so every entry to REQ starts a fresh timeout window.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_pc_load    = 1'b0;
    w_instr_load = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ack_i) begin
          w_instr_load = 1'b1;
          w_state_nxt  = S_HOLD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (exec_done_i) begin
          w_pc_load   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_ERR: w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc    <= PC_RST;
      r_instr <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_pc_load) begin
        r_pc <= w_pc_nxt;
      end
      if (w_instr_load) begin
        r_instr <= imem_rdata_i32;
      end
    end
  end

  assign imem_req_o    = (r_state == S_REQ);
  assign instr_valid_o = (r_state == S_HOLD);
  assign err_o         = (r_state == S_ERR);
  assign imem_addr_o32 = r_pc;
  assign pc_o32        = r_pc;
  assign pc_plus4_o32  = w_pc_plus4;
  assign instr_o32     = r_instr;
  assign op_o6         = r_instr[31:26];
  assign funct_o6      = r_instr[5:0];

endmodule
